// File: rtl/firebird7_in_gate1_tessent_tdr_w19_ctrl.sv
// IJTAG test data register driving the select and data inputs of the gate1 19-bit data mux.
// Build option: define FIREBIRD7_TDR_FUNC_CAPTURE_EN to capture functional_data_in (default: update-stage readback).
module firebird7_in_gate1_tessent_tdr_w19_ctrl #(
    parameter int unsigned       DATA_W     = 19,
    parameter logic [DATA_W-1:0] RESET_DATA = '0,
    parameter logic              RESET_SEL  = 1'b0
) (
    input  logic              ijtag_tck,
    input  logic              ijtag_reset,
    input  logic              ijtag_sel,
    input  logic              ijtag_ce,
    input  logic              ijtag_se,
    input  logic              ijtag_ue,
    input  logic              ijtag_si,
    output logic              ijtag_so,
    input  logic [DATA_W-1:0] functional_data_in,
    output logic [DATA_W-1:0] ijtag_data_out,
    output logic              ijtag_select_out,
    output logic              update_strobe
);

    logic [DATA_W:0]   shift_reg_q, shift_reg_d;
    logic              upd_sel_q, upd_sel_d;
    logic [DATA_W-1:0] upd_data_q, upd_data_d;
    logic              update_strobe_q, update_strobe_d;
    logic [DATA_W-1:0] capture_data;
    logic              do_capture, do_shift, do_update;

    // Only one operation per cycle: capture beats shift, shift beats update.
    assign do_capture = ijtag_sel & ijtag_ce;
    assign do_shift   = ijtag_sel & ijtag_se & ~ijtag_ce;
    assign do_update  = ijtag_sel & ijtag_ue & ~ijtag_ce & ~ijtag_se;

`ifdef FIREBIRD7_TDR_FUNC_CAPTURE_EN
    assign capture_data = functional_data_in;
`else
    logic unused_functional_data;
    assign unused_functional_data = ^functional_data_in;
    assign capture_data           = upd_data_q;
`endif

    always_comb begin
        shift_reg_d     = shift_reg_q;
        upd_sel_d       = upd_sel_q;
        upd_data_d      = upd_data_q;
        update_strobe_d = 1'b0;
        if (do_capture) begin
            shift_reg_d = {upd_sel_q, capture_data};
        end else if (do_shift) begin
            shift_reg_d = {ijtag_si, shift_reg_q[DATA_W:1]};
        end else if (do_update) begin
            upd_sel_d       = shift_reg_q[DATA_W];
            upd_data_d      = shift_reg_q[DATA_W-1:0];
            update_strobe_d = 1'b1;
        end
    end

    always_ff @(posedge ijtag_tck) begin
        if (ijtag_reset) begin
            shift_reg_q     <= '0;
            upd_sel_q       <= RESET_SEL;
            upd_data_q      <= RESET_DATA;
            update_strobe_q <= 1'b0;
        end else begin
            shift_reg_q     <= shift_reg_d;
            upd_sel_q       <= upd_sel_d;
            upd_data_q      <= upd_data_d;
            update_strobe_q <= update_strobe_d;
        end
    end

    // The mux only ever sees the update stage, never the shift path.
    assign ijtag_so         = shift_reg_q[0];
    assign ijtag_data_out   = upd_data_q;
    assign ijtag_select_out = upd_sel_q;
    assign update_strobe    = update_strobe_q;

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_tdr_w19_ctrl.sv
// Self-checking bench for firebird7_in_gate1_tessent_tdr_w19_ctrl: directed scenarios then random cycles
// against an arithmetic chain model (honours FIREBIRD7_TDR_FUNC_CAPTURE_EN like the design).
module tb_firebird7_in_gate1_tessent_tdr_w19_ctrl;

    localparam int DATA_W  = 19;
    localparam int CHAIN_N = DATA_W + 1;
    localparam int TOP     = 1 << DATA_W;

    logic              ijtag_tck = 1'b0;
    logic              ijtag_reset = 1'b1;
    logic              ijtag_sel = 1'b0;
    logic              ijtag_ce = 1'b0;
    logic              ijtag_se = 1'b0;
    logic              ijtag_ue = 1'b0;
    logic              ijtag_si = 1'b0;
    logic              ijtag_so;
    logic [DATA_W-1:0] functional_data_in = '0;
    logic [DATA_W-1:0] ijtag_data_out;
    logic              ijtag_select_out;
    logic              update_strobe;

    int checks = 0;
    int failures = 0;

    // Reference model: the chain as a plain integer, update stage as select + data values.
    int chain_m  = 0;
    int usel_m   = 0;
    int udata_m  = 0;
    int strobe_m = 0;

    firebird7_in_gate1_tessent_tdr_w19_ctrl dut (
        .ijtag_tck          (ijtag_tck),
        .ijtag_reset        (ijtag_reset),
        .ijtag_sel          (ijtag_sel),
        .ijtag_ce           (ijtag_ce),
        .ijtag_se           (ijtag_se),
        .ijtag_ue           (ijtag_ue),
        .ijtag_si           (ijtag_si),
        .ijtag_so           (ijtag_so),
        .functional_data_in (functional_data_in),
        .ijtag_data_out     (ijtag_data_out),
        .ijtag_select_out   (ijtag_select_out),
        .update_strobe      (update_strobe)
    );

    always #5 ijtag_tck = ~ijtag_tck;

    function automatic int capture_value();
`ifdef FIREBIRD7_TDR_FUNC_CAPTURE_EN
        return usel_m * TOP + int'(functional_data_in);
`else
        return usel_m * TOP + udata_m;
`endif
    endfunction

    task automatic checkOutput(input string tag);
        logic              exp_so, exp_sel, exp_strobe;
        logic [DATA_W-1:0] exp_data;
        exp_so     = 1'((chain_m % 2) != 0);
        exp_sel    = 1'(usel_m != 0);
        exp_strobe = 1'(strobe_m != 0);
        exp_data   = DATA_W'(udata_m);
        checks += 4;
        assert (ijtag_so === exp_so) else begin
            failures++;
            $error("[TB] FAIL %s so observed=%0b expected=%0b", tag, ijtag_so, exp_so);
        end
        assert (ijtag_select_out === exp_sel) else begin
            failures++;
            $error("[TB] FAIL %s select_out observed=%0b expected=%0b", tag, ijtag_select_out, exp_sel);
        end
        assert (ijtag_data_out === exp_data) else begin
            failures++;
            $error("[TB] FAIL %s data_out observed=%05h expected=%05h", tag, ijtag_data_out, exp_data);
        end
        assert (update_strobe === exp_strobe) else begin
            failures++;
            $error("[TB] FAIL %s strobe observed=%0b expected=%0b", tag, update_strobe, exp_strobe);
        end
    endtask

    // One clock cycle: drive inputs, advance the model by the same rules, then compare after the edge.
    task automatic applyStimulus(input logic rst, input logic sel, input logic ce, input logic se,
                                 input logic ue, input logic si, input string tag);
        ijtag_reset = rst;
        ijtag_sel   = sel;
        ijtag_ce    = ce;
        ijtag_se    = se;
        ijtag_ue    = ue;
        ijtag_si    = si;
        strobe_m    = 0;
        if (rst) begin
            chain_m = 0;
            usel_m  = 0;
            udata_m = 0;
        end else if (sel && ce) begin
            chain_m = capture_value();
        end else if (sel && se) begin
            chain_m = chain_m / 2 + (si ? TOP : 0);
        end else if (sel && ue) begin
            usel_m   = chain_m / TOP;
            udata_m  = chain_m % TOP;
            strobe_m = 1;
        end
        @(posedge ijtag_tck);
        #1;
        checkOutput(tag);
    endtask

    task automatic shiftWord(input int value, input int nbits, input string tag);
        for (int i = 0; i < nbits; i++)
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'((value >> i) & 1), tag);
    endtask

    initial begin
        int          got;
        int          expect_seq;
        logic        rr, rs, rc, rh, ru;

        $display("[TB] start");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "reset0");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "reset1");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "idle_after_reset");

        // Shift 0x80001 in LSB-first, then commit it.
        shiftWord(32'h80001, CHAIN_N, "shift_80001");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "update_80001");
        checks++;
        assert (ijtag_select_out === 1'b1 && ijtag_data_out === 19'h00001) else begin
            failures++;
            $error("[TB] FAIL test2_commit observed=%0b/%05h expected=1/00001", ijtag_select_out, ijtag_data_out);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "strobe_drop");

        // Capture, then read the chain out with si=0.
        functional_data_in = 19'h5A5A5;
        expect_seq = capture_value();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "capture_5a5a5");
        got = 0;
        for (int i = 0; i < CHAIN_N; i++) begin
            got = got | (int'(ijtag_so) << i);
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "shift_out");
        end
        checks++;
        assert (got === expect_seq) else begin
            failures++;
            $error("[TB] FAIL capture_readout observed=%05h expected=%05h", got, expect_seq);
        end

        // Deselected: every enable ignored.
        shiftWord(32'hA5F3C, CHAIN_N, "reload");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "desel_ce");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "desel_se");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "desel_ue");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, "desel_all");

        // ce with ue after a shift: capture wins, no commit.
        shiftWord(32'h3C3C3, 7, "pre_ceue");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "ce_ue_together");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, "se_ue_together");

        // Back-to-back updates each pulse the strobe.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "b2b_update0");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "b2b_update1");

        // Reset in the middle of a shift, then a clean shift + update.
        shiftWord(32'hFFFFF, 10, "pre_reset_shift");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "reset_midshift");
        shiftWord(32'h80001, CHAIN_N, "reshift_80001");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "reupdate_80001");

        // Overshift wraps: 30 bits, oldest bits emerge on so.
        shiftWord(32'h2AB1_5C3D, 30, "overshift");

        for (int n = 0; n < 400; n++) begin
            rr = 1'($urandom_range(0, 49) == 0);
            rs = 1'($urandom_range(0, 7) != 0);
            rc = 1'($urandom_range(0, 5) == 0);
            rh = 1'($urandom_range(0, 1));
            ru = 1'($urandom_range(0, 3) == 0);
            functional_data_in = DATA_W'($urandom);
            applyStimulus(rr, rs, rc, rh, ru, 1'($urandom_range(0, 1)), "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
